mult_seq: RTL and testbench

//  Iterative shift-and-add unsigned multiplier sequencer for the execute stage.

---
 rtl/mult_seq_pkg.sv | 14 +
 rtl/mult_seq_cla_add.sv | 62 ++++++
 rtl/mult_seq.sv | 123 ++++++++++++
 tb/tb_mult_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared constants for the iterative execute-stage sequencers (multiplier, divider).
// Holds the FSM state encoding and the default operand/counter widths.
package mult_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mult_seq_cla_add.sv
// WIDTH-bit carry-lookahead adder assembled from 4-bit group-lookahead cells.
// Group carries ripple between cells; each cell resolves its four carries in parallel.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // generate/propagate terms and flattened lookahead carries
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    sum    = p_s ^ c_s[3:0];
    cout   = c_s[4];
  end

endmodule

module cla_add
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic [NGRP:0] gc_s;

  assign gc_s[0] = cin;
  assign cout    = gc_s[NGRP];

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla4 u_cla4 (
      .a   (a[gi*4 +: 4]),
      .b   (b[gi*4 +: 4]),
      .cin (gc_s[gi]),
      .sum (sum[gi*4 +: 4]),
      .cout(gc_s[gi+1])
    );
  end

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-and-add unsigned multiplier: one partial-product step per cycle on a
// shared carry-lookahead adder, fixed WIDTH-cycle run, one-cycle done strobe.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   mcand_r;
  // The accumulator's extra top bit is zero after every shift, so only WIDTH bits are kept;
  // the adder carry-out lands in acc_r[WIDTH-1] once the sum is shifted right.
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   mq_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] product_r;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;
  logic               ready_s;
  logic               accept_s;
  logic               last_s;

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode; the unused encoding falls back to idle
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // handshake outputs decoded from the current state
  always_comb begin
    ready_s = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = !rst;
      ST_RUN:  busy    = 1'b1;
      ST_DONE: begin
        ready_s = !rst;
        done    = 1'b1;
      end
      default: ready_s = !rst;
    endcase
  end

  // partial-product selection and step-control decode
  always_comb begin
    if (mq_r[0]) addend_s = mcand_r;
    else         addend_s = {WIDTH{1'b0}};
    accept_s = ready_s && start;
    last_s   = (cnt_r == CNT_W'(1));
  end

  cla_add #(.WIDTH(WIDTH)) u_cla_add (
    .a   (acc_r),
    .b   (addend_s),
    .cin (1'b0),
    .sum (sum_s),
    .cout(cout_s)
  );

  // operand capture, add-and-shift step, and product latch on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r   <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      mq_r      <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else if (accept_s) begin
      mcand_r <= mcand;
      acc_r   <= {WIDTH{1'b0}};
      mq_r    <= mplier;
      cnt_r   <= CNT_W'(WIDTH);
    end else if (state_r == ST_RUN) begin
      acc_r <= {cout_s, sum_s[WIDTH-1:1]};
      mq_r  <= {sum_s[0], mq_r[WIDTH-1:1]};
      cnt_r <= cnt_r - CNT_W'(1);
      if (last_s) begin
        product_r <= {cout_s, sum_s, mq_r[WIDTH-1:1]};
      end
    end
  end

  assign ready   = ready_s;
  assign product = product_r;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed table, multi-cycle corner sequences,
// and randomized operations compared against plain a*b.
module tb_mult_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          ready;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int            n_vec = 0;
  int            n_err = 0;
  logic [2*W-1:0] prev_exp;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl[8];

  mult_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from a ready state and follow it to its done strobe.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string tag);
    int k;
    bit stable;
    chk({tag, " ready"}, 32'(ready), 32'd1);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    tick();
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    k = 0;
    stable = 1'b1;
    while (!done && k < 40) begin
      if (!busy || ready || product !== prev_exp) stable = 1'b0;
      tick();
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(W));
    chk({tag, " product"}, product, exp);
    chk({tag, " hold"}, 32'(stable), 32'd1);
    prev_exp = exp;
  endtask

  initial begin
    int k;
    int ndone;
    bit stable;
    logic [W-1:0] ra, rb;

    tbl[0] = '{16'd3,     16'd5,     32'h0000000F};
    tbl[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
    tbl[2] = '{16'h0000,  16'h1234,  32'h00000000};
    tbl[3] = '{16'h1234,  16'h0000,  32'h00000000};
    tbl[4] = '{16'h0001,  16'hFFFF,  32'h0000FFFF};
    tbl[5] = '{16'h8000,  16'h0002,  32'h00010000};
    tbl[6] = '{16'h00FF,  16'h0100,  32'h0000FF00};
    tbl[7] = '{16'h8000,  16'h8000,  32'h40000000};

    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", product, 32'd0);
    prev_exp = '0;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("tbl%0d", i));
      tick();
      chk($sformatf("tbl%0d done width", i), 32'(done), 32'd0);
    end

    // start while busy must be ignored
    start = 1'b1; mcand = 16'd7; mplier = 16'd9;
    tick();
    k = 0;
    while (!done && k < 40) begin
      if (k == 4) begin
        start = 1'b1; mcand = 16'd2; mplier = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    chk("busy-start latency", 32'(k), 32'(W));
    chk("busy-start product", product, 32'd63);
    prev_exp = 32'd63;
    ndone = 0;
    repeat (20) begin
      tick();
      if (done) ndone++;
    end
    chk("busy-start extra done", 32'(ndone), 32'd0);
    chk("busy-start product hold", product, 32'd63);

    // back-to-back start in the done cycle
    run_op(16'd10, 16'd10, 32'd100, "b2b first");
    start = 1'b1; mcand = 16'd4; mplier = 16'd4;
    tick();
    start = 1'b0;
    k = 1;
    stable = 1'b1;
    while (!done && k < 40) begin
      if (product !== 32'd100) stable = 1'b0;
      tick();
      k++;
    end
    chk("b2b done spacing", 32'(k), 32'(W + 1));
    chk("b2b product", product, 32'd16);
    chk("b2b hold", 32'(stable), 32'd1);
    prev_exp = 32'd16;

    // reset in the middle of a run
    start = 1'b1; mcand = 16'd100; mplier = 16'd100;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst product", product, 32'd0);
    ndone = 0;
    repeat (20) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst no done", 32'(ndone), 32'd0);
    prev_exp = '0;
    run_op(16'd6, 16'd7, 32'd42, "after rst");

    // randomized operations with random idle gaps (gap 0 = back-to-back)
    for (int i = 0; i < 3000; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        if (g == 0) chk("rand done width", 32'(done), 32'd0);
      end
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
      run_op(ra, rb, {{W{1'b0}}, ra} * {{W{1'b0}}, rb}, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
